// File: rtl/jtframe_cenmon.sv
// jtframe_cenmon: clock-enable monitor.
// Counts cen pulses over a fixed window of WIN clk cycles. At the end of each
// window it reports the pulse count, under/over-rate flags, a stuck flag and,
// when the macro JTFRAME_CENMON_GAP_EN is defined, the smallest and largest
// cen-to-cen spacing seen in that window. Without the macro the gap outputs
// are tied to zero and no gap logic is built.
module jtframe_cenmon #(
  parameter int WIN     = 48000,
  parameter int CW      = 16,
  parameter int EXP_MIN = 3579,
  parameter int EXP_MAX = 3580,
  parameter int GAPW    = 8
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cen,
  input  logic            clr,
  output logic [CW-1:0]   count,
  output logic            valid,
  output logic            too_slow,
  output logic            too_fast,
  output logic            stuck,
  output logic [GAPW-1:0] min_gap,
  output logic [GAPW-1:0] max_gap
);

  localparam int WCW = $clog2(WIN);
  localparam logic [WCW-1:0] WC_LAST = WCW'(WIN - 1);

  logic [WCW-1:0] wc_q, wc_d;
  logic [CW-1:0]  pc_q, pc_d, pc_fin;
  logic           seen_hi_q, seen_hi_d, seen_lo_q, seen_lo_d;
  logic           hi_fin, lo_fin;
  logic           close;
  logic [31:0]    pc_ext;

  logic [CW-1:0]  count_q;
  logic           valid_q, too_slow_q, too_fast_q, stuck_q;

  // A clr on the closing cycle discards the window, so it blocks the report.
  assign close  = (wc_q == WC_LAST) && !clr;
  // Final count includes a cen landing on the closing cycle; saturates.
  assign pc_fin = (cen && (pc_q != {CW{1'b1}})) ? pc_q + CW'(1) : pc_q;
  assign pc_ext = 32'(pc_fin);
  // Stuck means cen never toggled level within the window.
  assign hi_fin = seen_hi_q | cen;
  assign lo_fin = seen_lo_q | ~cen;

  // Next-state for window counter, pulse counter and level-seen tracking.
  always_comb begin
    wc_d      = (wc_q == WC_LAST) ? '0 : wc_q + WCW'(1);
    pc_d      = close ? '0 : pc_fin;
    seen_hi_d = close ? 1'b0 : hi_fin;
    seen_lo_d = close ? 1'b0 : lo_fin;
    if (clr) begin
      wc_d      = '0;
      pc_d      = '0;
      seen_hi_d = 1'b0;
      seen_lo_d = 1'b0;
    end
  end

  // Window state and report registers; report captured on the closing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc_q       <= '0;
      pc_q       <= '0;
      seen_hi_q  <= 1'b0;
      seen_lo_q  <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      too_slow_q <= 1'b0;
      too_fast_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      wc_q      <= wc_d;
      pc_q      <= pc_d;
      seen_hi_q <= seen_hi_d;
      seen_lo_q <= seen_lo_d;
      valid_q   <= close;
      if (close) begin
        count_q    <= pc_fin;
        too_slow_q <= pc_ext < 32'(EXP_MIN);
        too_fast_q <= pc_ext > 32'(EXP_MAX);
        stuck_q    <= !hi_fin || !lo_fin;
      end
    end
  end

  assign count    = count_q;
  assign valid    = valid_q;
  assign too_slow = too_slow_q;
  assign too_fast = too_fast_q;
  assign stuck    = stuck_q;

`ifdef JTFRAME_CENMON_GAP_EN
  logic [GAPW-1:0] gc_q, gc_d, rmin_q, rmin_d, rmax_q, rmax_d;
  logic [GAPW-1:0] gap, min_fin, max_fin, min_gap_q, max_gap_q;
  logic            armed_q, armed_d, rec;

  // Gap is cycles since previous cen plus one, saturating at all ones.
  assign gap     = (gc_q == {GAPW{1'b1}}) ? gc_q : gc_q + GAPW'(1);
  // The first cen after reset/clr only arms the history.
  assign rec     = cen && armed_q;
  assign min_fin = (rec && (gap < rmin_q)) ? gap : rmin_q;
  assign max_fin = (rec && (gap > rmax_q)) ? gap : rmax_q;

  // Next-state for gap counter, history and running min/max.
  always_comb begin
    gc_d    = cen ? '0 : ((gc_q == {GAPW{1'b1}}) ? gc_q : gc_q + GAPW'(1));
    armed_d = armed_q | cen;
    rmin_d  = close ? {GAPW{1'b1}} : min_fin;
    rmax_d  = close ? '0 : max_fin;
    if (clr) begin
      gc_d    = '0;
      armed_d = 1'b0;
      rmin_d  = {GAPW{1'b1}};
      rmax_d  = '0;
    end
  end

  // Gap state and gap report registers, captured alongside count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gc_q      <= '0;
      armed_q   <= 1'b0;
      rmin_q    <= {GAPW{1'b1}};
      rmax_q    <= '0;
      min_gap_q <= {GAPW{1'b1}};
      max_gap_q <= '0;
    end else begin
      gc_q    <= gc_d;
      armed_q <= armed_d;
      rmin_q  <= rmin_d;
      rmax_q  <= rmax_d;
      if (close) begin
        min_gap_q <= min_fin;
        max_gap_q <= max_fin;
      end
    end
  end

  assign min_gap = min_gap_q;
  assign max_gap = max_gap_q;
`else
  assign min_gap = '0;
  assign max_gap = '0;
`endif

endmodule

// File: tb/tb_jtframe_cenmon.sv
// Directed testbench for jtframe_cenmon: three instances (small window,
// small window with narrow counter, default parameters with a 3.57 MHz
// fractional cen), checked with immediate assertions.
module tb_jtframe_cenmon;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_a = 1'b0, clr_n = 1'b0;
  logic cen_a = 1'b0, cen_b = 1'b0, cen_c = 1'b0;

  logic [15:0] count_a, count_c;
  logic [3:0]  count_b;
  logic valid_a, slow_a, fast_a, stuck_a;
  logic valid_b, slow_b, fast_b, stuck_b;
  logic valid_c, slow_c, fast_c, stuck_c;
  logic [7:0] ming_a, maxg_a, ming_b, maxg_b, ming_c, maxg_c;

  int tests = 0, fails = 0;
  int wcm = 0, pos = 0, acc = 0;

  always #5 clk = ~clk;

  jtframe_cenmon #(.WIN(48), .CW(16), .EXP_MIN(12), .EXP_MAX(12), .GAPW(8)) u_a (
    .rst(rst), .clk(clk), .cen(cen_a), .clr(clr_a),
    .count(count_a), .valid(valid_a), .too_slow(slow_a), .too_fast(fast_a),
    .stuck(stuck_a), .min_gap(ming_a), .max_gap(maxg_a));

  jtframe_cenmon #(.WIN(48), .CW(4), .EXP_MIN(12), .EXP_MAX(12), .GAPW(8)) u_b (
    .rst(rst), .clk(clk), .cen(cen_b), .clr(clr_n),
    .count(count_b), .valid(valid_b), .too_slow(slow_b), .too_fast(fast_b),
    .stuck(stuck_b), .min_gap(ming_b), .max_gap(maxg_b));

  jtframe_cenmon u_c (
    .rst(rst), .clk(clk), .cen(cen_c), .clr(clr_n),
    .count(count_c), .valid(valid_c), .too_slow(slow_c), .too_fast(fast_c),
    .stuck(stuck_c), .min_gap(ming_c), .max_gap(maxg_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected gap output: the value itself when gap logic is built, else 0.
  function automatic logic [31:0] g(input logic [31:0] v);
`ifdef JTFRAME_CENMON_GAP_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  // One clk cycle: advance the 3.579545/48 fractional cen, then sample at +1.
  task automatic step();
    cen_c = 1'b0;
    acc += 3579545;
    if (acc >= 48000000) begin
      acc -= 48000000;
      cen_c = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: cen every 4th cycle, 1: cen held 0, 2: cen held 1.
  task automatic run_a(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      cen_a = (mode == 0) ? ((pos % 4) == 0) : (mode == 2);
      pos++;
      step();
      check("valid_a", valid_a, (wcm == 47));
      wcm = (wcm == 47) ? 0 : wcm + 1;
    end
  endtask

  initial begin
    bit got_c;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_count", count_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_slow", slow_a, 0);
    check("rst_fast", fast_a, 0);
    check("rst_stuck", stuck_a, 0);
    check("rst_min_gap", ming_a, g(255));
    check("rst_max_gap", maxg_a, 0);
    check("rst_count_b", count_b, 0);
    cen_b = 1'b1;
    rst = 1'b0;

    // Window 1: cen every 4th clk
    run_a(48, 0);
    check("w1_count", count_a, 12);
    check("w1_slow", slow_a, 0);
    check("w1_fast", fast_a, 0);
    check("w1_stuck", stuck_a, 0);
    check("w1_min_gap", ming_a, g(4));
    check("w1_max_gap", maxg_a, g(4));
    // Narrow counter with cen held high saturates
    check("b_valid", valid_b, 1);
    check("b_count_sat", count_b, 15);
    check("b_fast", fast_b, 1);
    check("b_slow", slow_b, 0);
    check("b_stuck", stuck_b, 1);

    // Window 2: same pattern, gap crossing the boundary is 4
    run_a(48, 0);
    check("w2_count", count_a, 12);
    check("w2_min_gap", ming_a, g(4));
    check("w2_max_gap", maxg_a, g(4));

    // Window 3: cen held 0
    run_a(48, 1);
    check("w3_count", count_a, 0);
    check("w3_slow", slow_a, 1);
    check("w3_fast", fast_a, 0);
    check("w3_stuck", stuck_a, 1);
    check("w3_min_gap", ming_a, g(255));
    check("w3_max_gap", maxg_a, 0);

    // Window 4: cen held 1; first gap spans the idle window (52 cycles)
    run_a(48, 2);
    check("w4_count", count_a, 48);
    check("w4_fast", fast_a, 1);
    check("w4_slow", slow_a, 0);
    check("w4_stuck", stuck_a, 1);
    check("w4_min_gap", ming_a, g(1));
    check("w4_max_gap", maxg_a, g(52));

    // Window 5: cen held 1 throughout
    run_a(48, 2);
    check("w5_count", count_a, 48);
    check("w5_min_gap", ming_a, g(1));
    check("w5_max_gap", maxg_a, g(1));

    // clr at wc=20 with a coinciding cen
    pos = 0;
    run_a(20, 0);
    cen_a = 1'b1;
    clr_a = 1'b1;
    pos++;
    step();
    clr_a = 1'b0;
    check("clr_valid", valid_a, 0);
    check("clr_count_held", count_a, 48);
    wcm = 0;
    run_a(47, 0);
    check("clr_count_still", count_a, 48);
    check("clr_fast_still", fast_a, 1);
    run_a(1, 0);
    check("clr_count", count_a, 12);
    check("clr_fast", fast_a, 0);
    check("clr_stuck", stuck_a, 0);
    check("clr_min_gap", ming_a, g(4));
    check("clr_max_gap", maxg_a, g(4));

    // Default parameters with 3.57 MHz fractional cen
    cen_a = 1'b0;
    got_c = 1'b0;
    for (int i = 0; i < 50000 && !got_c; i++) begin
      step();
      got_c = valid_c;
    end
    check("c_valid_seen", got_c, 1);
    if (got_c) begin
      check("c_count_range", (count_c >= 16'd3579 && count_c <= 16'd3580), 1);
      check("c_slow", slow_c, 0);
      check("c_fast", fast_c, 0);
      check("c_stuck", stuck_c, 0);
      check("c_min_gap", ming_c, g(13));
      check("c_max_gap", maxg_c, g(14));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jtframe_cenmon.md
Name: jtframe_cenmon

Overview:
- Clock-enable monitor: consumes a cen strobe from any jtframe cen generator and measures its rate and pulse spacing over a fixed window of clk cycles.
- Reports per-window pulse count, under/over-rate flags, a stuck flag and min/max pulse gaps.
- Used in simulation benches and in the debug/OSD path to catch broken or drifting fractional cens, such as the 3.57 MHz one.

Parameters:
- WIN, 48000: window length in clk cycles (1 ms at 48 MHz); must be >=2.
- CW, 16: width of pulse counter and count output.
- EXP_MIN, 3579: minimum acceptable pulses per window.
- EXP_MAX, 3580: maximum acceptable pulses per window.
- GAPW, 8: width of gap counters and gap outputs.

Ports:
- rst  in  1  asynchronous reset, active high
- clk  in  1  system clock
- cen  in  1  monitored clock enable, sampled on clk rising edge
- clr  in  1  synchronous restart of current window
- count  out  CW  pulses counted in last completed window
- valid  out  1  one-cycle strobe: outputs updated
- too_slow  out  1  count < EXP_MIN
- too_fast  out  1  count > EXP_MAX
- stuck  out  1  cen constant (all 0 or all 1) for whole last window
- min_gap  out  GAPW  smallest cen-to-cen spacing in last window
- max_gap  out  GAPW  largest cen-to-cen spacing in last window

Behaviour:
- Reset: all outputs 0, except min_gap = all ones. Window counter wc, pulse counter pc, gap counter gc = 0; gap history invalid.
- Window counter:
  - wc counts 0..WIN-1 on every clk and wraps to 0.
  - Width is ceil(log2(WIN)).
  - Window closes on the cycle where wc==WIN-1.
- Pulse counter:
  - pc increments on each cycle with cen=1.
  - Saturates at all ones and never wraps.
  - A cen on the closing cycle counts toward the closing window.
- Report latency: on the closing cycle, register the final count (pc plus that cycle's cen) into count, and compute flags from that value. valid=1 on the following cycle only. pc restarts at 0 for the next window.
- Flags: too_slow and too_fast are recomputed each window and held until the next report.
- stuck:
  - Set when the window saw either 0 pulses or WIN pulses, i.e. cen high every cycle.
  - stuck=1 implies too_slow or too_fast whenever EXP_MIN>0 and EXP_MAX<WIN.
- Gap measurement:
  - gc counts clk cycles since the previous cen and saturates at all ones.
  - On a cen with valid history, gap = gc+1 (consecutive cens give gap 1). It updates running min and max, then gc restarts.
  - The first cen after reset or clr only arms the history; no gap is recorded.
  - A gap spanning a window boundary is credited to the window where its closing cen lands.
- Gap report: min_gap and max_gap are registered together with count. If no gap was recorded in the window, min_gap = all ones and max_gap = 0. Running min/max reinitialise after each report.
- clr:
  - Synchronous. On the same cycle it sets wc, pc, gc to 0, clears the running min/max and invalidates gap history.
  - Output registers and flags keep their last values; no valid strobe.
  - A cen coinciding with clr is ignored.
  - clr on the closing cycle has priority: the window is discarded and no report is made.
- Reset mid-window: immediate return to reset state; partial window discarded.

Optional Feature:
- Macro: JTFRAME_CENMON_GAP_EN.
- Defined: gap counter and min/max logic are built as described above.
- Undefined: no gap logic is synthesised; min_gap and max_gap are tied to 0; count, flags and stuck are unchanged.

Test Plan:
1. WIN=48, EXP_MIN=12, EXP_MAX=12, cen every 4th clk -> valid on cycle 48 after reset release, count=12, flags 0, min_gap=max_gap=4 from the second window onward.
2. cen held 0 for a full window -> count=0, too_slow=1, stuck=1, min_gap=all ones, max_gap=0.
3. cen held 1, WIN=48 -> count=48, too_fast=1, stuck=1, min_gap=max_gap=1.
4. Default parameters, jtframe 3.57 MHz cen driven at 48 MHz -> count in 3579..3580 every window, flags 0, min_gap=13, max_gap=14.
5. CW=4, WIN=48, cen always 1 -> count saturates at 15, too_fast=1.
6. clr asserted at wc=20 with cen every 4th clk -> no valid that cycle; next valid 48 cycles after clr, count=12; outputs unchanged in between.
